game_timer: RTL
===============

// Module: game_timer
// PURPOSE
//  Seconds-resolution game countdown that consumes the 1-cycle `timer` tick of the upstream countdown block.
//  Loads START_SECS on `start` and decrements once per tick. Keeps a binary count and two BCD digits for the seven-seg drivers.
//  Flags expiry to the game FSM. Drives the upstream block's `enable` so tick phase restarts on every start/resume.
// PARAMETERS
//  START_SECS  60  seconds loaded on start; legal range 1..99 (elaboration $error outside range)
// PORTS
//  clk        in   1  system clock (50 MHz)
//  reset      in   1  synchronous, active-high reset
//  start      in   1  1-cycle pulse: (re)load START_SECS and run
//  pause      in   1  level: hold count while high
//  tick       in   1  1-cycle pulse from upstream countdown `timer`
//  tick_en    out  1  drives upstream countdown `enable`
//  secs_left  out  7  remaining seconds, binary
//  bcd_tens   out  4  remaining seconds, tens digit (0..9)
//  bcd_ones   out  4  remaining seconds, ones digit (0..9)
//  running    out  1  high in RUN
//  expired    out  1  high in EXPIRED (level)
//  done       out  1  1-cycle pulse on transition to EXPIRED
// BEHAVIOUR
//  Clock, reset and output timing
//  - One clock; reset is synchronous and active-high.
//  - Reset: state=IDLE, secs_left=0, bcd_tens=0, bcd_ones=0, done=0; hence tick_en=0, running=0, expired=0.
//  - Reset wins over every other input in the same cycle; reset mid-run aborts with no done pulse.
//  - All outputs registered, except tick_en/running/expired, which decode the state register directly.
//  FSM states: IDLE, RUN, PAUSED, EXPIRED.
//  - IDLE/EXPIRED + start -> RUN; load secs_left=START_SECS and the BCD digits of START_SECS.
//  - RUN + start -> RUN; reload as above (restart); start has priority over a same-cycle tick or pause.
//  - RUN + pause (no start) -> PAUSED; a same-cycle tick is discarded.
//  - PAUSED + !pause -> RUN; PAUSED + start -> RUN with reload.
//  - RUN + tick, secs_left>1 -> secs_left-1.
//  - RUN + tick, secs_left==1 -> secs_left=0, state=EXPIRED, done=1 for exactly that one cycle.
//  - tick outside RUN is ignored.
//  - EXPIRED holds at 0 until start or reset.
//  Counting and upstream phase
//  - Latency: tick sampled at edge k; new secs_left, BCD and done are visible after edge k.
//  - tick_en = (state==RUN). Leaving RUN clears the upstream counter, so a paused partial second is lost.
//    The first tick after start/resume therefore arrives a full upstream period later.
//  - BCD decrement: ones>0 -> ones-1; ones==0 -> ones=9, tens-1.
//    BCD must equal secs_left at all times; secs_left never wraps below 0.
//  - A pause asserted while already in IDLE/EXPIRED has no effect.
// TESTING
//  - Reset then idle; 5 tick pulses -> secs_left=0, tick_en=0, no done, state IDLE.
//  - START_SECS=60: start, then 60 ticks 20 cycles apart.
//    -> 59 after tick 1 (bcd 5/9); 10 after tick 50 (bcd 1/0); 9 after tick 51 (bcd 0/9).
//    -> done single pulse on tick 60; expired=1; a 61st tick changes nothing.
//  - Pause at 42 (bcd 4/2): 3 ticks while paused -> still 42, tick_en=0; release -> tick_en=1, next tick -> 41.
//  - At 7 with running=1: drive start and tick in the same cycle -> 60 (bcd 6/0), no decrement, no done.
//  - Reset asserted at 15 during RUN -> next cycle all outputs at reset values, done never pulses.
//  - From EXPIRED, start -> RUN with 60; START_SECS=1 build: start + 1 tick -> done pulse, expired.

Source files
------------

// File: rtl/game_timer.sv
// game_timer: seconds countdown driven by the upstream 1-cycle tick, with binary and BCD views.
// Latency: a tick/start sampled at edge k is visible on secs/BCD/done right after edge k.
// Backpressure: none; tick_en gates the upstream divider, and ticks outside RUN are dropped.
//
// Ports:
//   clk_i        system clock
//   reset_i      synchronous, active-high reset
//   start_i      1-cycle pulse: (re)load START_SECS and run
//   pause_i      level: hold the count while high
//   tick_i       1-cycle pulse from the upstream countdown
//   tick_en_o    enable for the upstream countdown (high only in RUN)
//   secs_left_o  remaining seconds, binary
//   bcd_tens_o   remaining seconds, tens digit
//   bcd_ones_o   remaining seconds, ones digit
//   running_o    high in RUN
//   expired_o    high in EXPIRED
//   done_o       1-cycle pulse on entry to EXPIRED
module game_timer #(
    parameter int START_SECS = 60
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       tick_i,
    output logic       tick_en_o,
    output logic [6:0] secs_left_o,
    output logic [3:0] bcd_tens_o,
    output logic [3:0] bcd_ones_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       done_o
);

    generate
        if (START_SECS < 1 || START_SECS > 99) begin : g_bad_start
            $error("game_timer: START_SECS must be in 1..99");
        end
    endgenerate

    localparam logic [6:0] START_BIN  = 7'(START_SECS);
    localparam logic [3:0] START_TENS = 4'(START_SECS / 10);
    localparam logic [3:0] START_ONES = 4'(START_SECS % 10);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] secs_q,  secs_d;
    logic [3:0] tens_q,  tens_d;
    logic [3:0] ones_q,  ones_d;
    logic       done_q,  done_d;
    logic       load;

    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE, EXPIRED: begin
                // pause has no meaning here; only start leaves these states
                if (start_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // start beats pause, pause beats tick (the tick is discarded)
                if (start_i) begin
                    load = 1'b1;
                end else if (pause_i) begin
                    state_d = PAUSED;
                end else if (tick_i) begin
                    if (secs_q > 7'd1) begin
                        secs_d = secs_q - 7'd1;
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        // last second: clamp at zero rather than wrap
                        secs_d  = 7'd0;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                        state_d = EXPIRED;
                        done_d  = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else if (!pause_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            secs_d = START_BIN;
            tens_d = START_TENS;
            ones_d = START_ONES;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            secs_q  <= 7'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

    // Leaving RUN drops tick_en, which clears the upstream divider; a resumed
    // run therefore waits a full upstream period for its first tick.
    assign tick_en_o   = (state_q == RUN);
    assign running_o   = (state_q == RUN);
    assign expired_o   = (state_q == EXPIRED);
    assign secs_left_o = secs_q;
    assign bcd_tens_o  = tens_q;
    assign bcd_ones_o  = ones_q;
    assign done_o      = done_q;

endmodule
